// File: rtl/mem_io_pkg.sv
// Shared types and constants for the CPU memory / I/O responder.
package mem_io_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic [15:0] IO_SWITCH_ADDR = 16'hFFFF;
    localparam int          SRAM_ADDR_W    = 20;

endpackage

// File: rtl/reg_16.sv
// 16-bit load-enable register with synchronous active-high reset.
module reg_16 (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Load,
    input  logic [15:0] D,
    output logic [15:0] Q
);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            Q <= 16'h0000;
        end else if (Load) begin
            Q <= D;
        end
    end

endmodule

// File: rtl/mem_io_responder.sv
// Answers CPU memory requests from external SRAM, or from the switch/hex
// I/O port at IO_SWITCH_ADDR, with a one-cycle Ready completion pulse.
//
// state  | meaning
// IDLE   | waiting for Req; request fields latched on acceptance
// ACCESS | SRAM strobes active for WAIT_STATES cycles
// DONE   | Ready pulse, then back to IDLE
module mem_io_responder
    import mem_io_pkg::*;
#(
    parameter int WAIT_STATES = 2
) (
    input  logic                   Clk,
    input  logic                   Reset,
    input  logic                   Req,
    input  logic                   WE,
    input  logic [15:0]            Addr,
    input  logic [15:0]            WData,
    input  logic [15:0]            Switches,
    output logic [15:0]            RData,
    output logic                   Ready,
    output logic [15:0]            HexOut,
    output logic [SRAM_ADDR_W-1:0] SRAM_Addr,
    output logic                   SRAM_CE_N,
    output logic                   SRAM_OE_N,
    output logic                   SRAM_WE_N,
    output logic [15:0]            SRAM_DQ_Out,
    output logic                   SRAM_DQ_OE,
    input  logic [15:0]            SRAM_DQ_In
);

    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_STATES - 1);

    state_t      state, next_state;
    logic [3:0]  wait_cnt;
    logic [15:0] addr_q;
    logic [15:0] wdata_q;
    logic        we_q;
    logic [15:0] rdata_q;
    logic        accept;
    logic        io_hit;
    logic        hex_load;

    assign accept   = (state == IDLE) && Req;
    assign io_hit   = (Addr == IO_SWITCH_ADDR);
    assign hex_load = accept && io_hit && WE;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state    <= IDLE;
            wait_cnt <= 4'd0;
            addr_q   <= 16'h0000;
            wdata_q  <= 16'h0000;
            we_q     <= 1'b0;
            rdata_q  <= 16'h0000;
        end else begin
            state <= next_state;
            if (accept) begin
                addr_q   <= Addr;
                wdata_q  <= WData;
                we_q     <= WE;
                wait_cnt <= WAIT_LOAD;
                if (io_hit && !WE) begin
                    rdata_q <= Switches;
                end
            end else if (state == ACCESS) begin
                // Terminal count marks the last strobe cycle: read data is valid here.
                if (wait_cnt == 4'd0) begin
                    if (!we_q) begin
                        rdata_q <= SRAM_DQ_In;
                    end
                end else begin
                    wait_cnt <= wait_cnt - 4'd1;
                end
            end
        end
    end

    always_comb begin
        next_state = state;
        Ready      = 1'b0;
        SRAM_CE_N  = 1'b1;
        SRAM_OE_N  = 1'b1;
        SRAM_WE_N  = 1'b1;
        SRAM_DQ_OE = 1'b0;
        case (state)
            IDLE: begin
                if (Req) begin
                    next_state = io_hit ? DONE : ACCESS;
                end
            end
            ACCESS: begin
                SRAM_CE_N = 1'b0;
                if (we_q) begin
                    SRAM_WE_N  = 1'b0;
                    SRAM_DQ_OE = 1'b1;
                end else begin
                    SRAM_OE_N = 1'b0;
                end
                if (wait_cnt == 4'd0) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                Ready      = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    assign RData       = rdata_q;
    assign SRAM_Addr   = {{(SRAM_ADDR_W - 16){1'b0}}, addr_q};
    assign SRAM_DQ_Out = wdata_q;

    reg_16 u_hex_reg (
        .Clk   (Clk),
        .Reset (Reset),
        .Load  (hex_load),
        .D     (WData),
        .Q     (HexOut)
    );

endmodule

// File: doc/mem_io_responder.md
MEM_IO_RESPONDER -- requirements
Module: mem_io_responder

Interface
REQ-001 SHALL have parameter: WAIT_STATES, 2, number of SRAM access cycles per transaction (legal range 1..15).
REQ-002 SHALL have one clock and a synchronous, active-high reset: ports Clk and Reset.
REQ-003 Clk  input  1  system clock; all state updates on rising edge.
REQ-004 Reset  input  1  synchronous active-high reset.
REQ-005 Req  input  1  CPU memory request; held high by the initiator until Ready.
REQ-006 WE  input  1  1 = write, 0 = read; sampled at acceptance.
REQ-007 Addr  input  16  CPU word address (MAR); sampled at acceptance.
REQ-008 WData  input  16  write data (MDR); sampled at acceptance.
REQ-009 Switches  input  16  board switch value, read at I/O address.
REQ-010 RData  output  16  read data returned to the CPU MDR mux.
REQ-011 Ready  output  1  one-cycle completion pulse.
REQ-012 HexOut  output  16  hex display register.
REQ-013 SRAM_Addr  output  20  SRAM address, {4'h0, latched Addr}.
REQ-014 SRAM_CE_N, SRAM_OE_N, SRAM_WE_N  output  1 each  active-low SRAM strobes.
REQ-015 SRAM_DQ_Out  output  16  write data to the SRAM tristate buffer.
REQ-016 SRAM_DQ_OE  output  1  1 = drive SRAM_DQ_Out onto the SRAM bus.
REQ-017 SRAM_DQ_In  input  16  data read from the SRAM bus.

Function
REQ-018 SHALL implement an FSM with states IDLE, ACCESS and DONE.
REQ-019 IDLE: when Req=1, SHALL latch Addr, WE and WData, then go to ACCESS (SRAM address) or DONE (Addr=16'hFFFF).
REQ-020 ACCESS: SHALL stay exactly WAIT_STATES cycles using a 4-bit counter, then go to DONE.
REQ-021 During ACCESS, SRAM_CE_N=0; a read SHALL drive SRAM_OE_N=0 and SRAM_WE_N=1; a write SHALL drive SRAM_WE_N=0, SRAM_OE_N=1 and SRAM_DQ_OE=1 with SRAM_DQ_Out=latched WData.
REQ-022 A read SHALL capture SRAM_DQ_In into RData on the last ACCESS cycle.
REQ-023 I/O read (Addr=16'hFFFF, WE=0) SHALL load RData with Switches at acceptance; no SRAM strobe asserts.
REQ-024 I/O write (Addr=16'hFFFF, WE=1) SHALL load HexOut with WData at acceptance; no SRAM strobe asserts.
REQ-025 DONE: SHALL assert Ready=1 for exactly one cycle, then return to IDLE unconditionally.
REQ-026 RData SHALL hold its value until the next read completes; writes SHALL leave RData unchanged.
REQ-027 Latency from the accepting edge to Ready: SRAM access = WAIT_STATES+1 cycles; I/O access = 1 cycle.
REQ-028 Changes to Req, WE, Addr or WData after acceptance SHALL be ignored until the FSM returns to IDLE.
REQ-029 Req=1 in IDLE on the cycle after DONE SHALL start a new transaction; back-to-back transactions are legal.
REQ-030 Outside ACCESS, all SRAM strobes SHALL be 1 and SRAM_DQ_OE SHALL be 0.

Reset
REQ-031 Reset=1 SHALL force IDLE, counter=0, Ready=0, RData=16'h0000, HexOut=16'h0000, all SRAM strobes=1 and SRAM_DQ_OE=0 on the next edge.
REQ-032 Reset asserted mid-ACCESS SHALL abort the transaction with no Ready pulse, and strobes SHALL deassert on that edge.
REQ-033 Reset SHALL take priority over Req on the same edge.

Structure
REQ-034 Package mem_io_pkg SHALL hold the state enum, IO_SWITCH_ADDR=16'hFFFF and SRAM_ADDR_W=20.
REQ-035 HexOut SHALL be a single instance of the existing reg_16 register module.
REQ-036 The FSM, counter and strobe decode SHALL stay in mem_io_responder.

Verification
REQ-037 Reset, then SRAM read of Addr=16'h0010 with SRAM_DQ_In=16'hBEEF, WAIT_STATES=2 -> OE_N low for 2 cycles, Ready at edge+3, RData=16'hBEEF.
REQ-038 SRAM write of Addr=16'h0020, WData=16'h1234 -> WE_N low and DQ_OE=1 for 2 cycles, SRAM_Addr=20'h00020, RData unchanged.
REQ-039 I/O write of 16'h00AB to Addr=16'hFFFF, then I/O read with Switches=16'h5A5A -> HexOut=16'h00AB, RData=16'h5A5A, each Ready 1 cycle after acceptance, no strobes asserted.
REQ-040 Reset pulsed on the 1st ACCESS cycle of a write -> no Ready, strobes high on the next cycle, state IDLE.
REQ-041 Req held high continuously across two reads -> two Ready pulses separated by exactly WAIT_STATES+2 cycles.
REQ-042 Addr and WData changed mid-ACCESS -> SRAM_Addr and SRAM_DQ_Out hold the values latched at acceptance.
